// File: rtl/dac_tx_pkg.sv
// dac_tx_pkg: shared state encoding, frame width and DAC power-down codes for dac_tx_serial.
package dac_tx_pkg;
    typedef logic [1:0] state_t;
    localparam state_t IDLE  = 2'd0;
    localparam state_t SHIFT = 2'd1;
    localparam state_t GAP   = 2'd2;
    localparam int FRAME_W = 16;
    localparam logic [1:0] PD_NORMAL = 2'b00;
    localparam logic [1:0] PD_1K     = 2'b01;
    localparam logic [1:0] PD_100K   = 2'b10;
    localparam logic [1:0] PD_HIZ    = 2'b11;
endpackage

// File: rtl/dac_sclk_gen.sv
// dac_sclk_gen: clock-enable divider producing a registered SCLK and rise/fall strobes.
// When disabled the divider is cleared and SCLK parks high.
module dac_sclk_gen #(
    parameter int DIV_HALF = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    output logic sclk_o,
    output logic rise_en_o,
    output logic fall_en_o
);
    localparam int DW = DIV_HALF > 1 ? $clog2(DIV_HALF) : 1;
    logic [DW-1:0] div_q, div_d;
    logic sclk_q, sclk_d, term;
    always_comb begin
        term      = div_q == DW'(DIV_HALF - 1);
        div_d     = !en_i ? '0 : term ? '0 : div_q + 1'b1;
        sclk_d    = !en_i ? 1'b1 : term ? ~sclk_q : sclk_q;
        rise_en_o = en_i & term & ~sclk_q;
        fall_en_o = en_i & term & sclk_q;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            div_q  <= '0;
            sclk_q <= 1'b1;
        end else begin
            div_q  <= div_d;
            sclk_q <= sclk_d;
        end
    end
    assign sclk_o = sclk_q;
endmodule

// File: rtl/dac_tx_serial.sv
// dac_tx_serial: shifts {2'b00, pd_mode, din} MSB-first as a 16-bit frame to a serial DAC.
// Optional DAC_TX_TWOS_COMP_EN converts two's-complement din to offset binary at latch time.
module dac_tx_serial
    import dac_tx_pkg::*;
#(
    parameter int DIV_HALF = 2,
    parameter int GAP_CYC  = 2,
    parameter int DATA_W   = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_start,
    input  logic [DATA_W-1:0] din,
    input  logic [1:0]        pd_mode,
    output logic              sync_n,
    output logic              sclk,
    output logic              sdata,
    output logic              tx_busy,
    output logic              tx_done_tick
);
    localparam int GW  = GAP_CYC > 1 ? $clog2(GAP_CYC) : 1;
    localparam int PAD = FRAME_W - 4 - DATA_W;
    state_t state_q, state_d;
    logic [FRAME_W-1:0] shift_q, shift_d, frame;
    logic [3:0] bit_q, bit_d;
    logic [GW-1:0] gap_q, gap_d;
    logic sync_q, sync_d, done_q, done_d;
    logic [DATA_W-1:0] din_c;
    logic rise_en, fall_en;
`ifdef DAC_TX_TWOS_COMP_EN
    assign din_c = {~din[DATA_W-1], din[DATA_W-2:0]};
`else
    assign din_c = din;
`endif
    assign frame = FRAME_W'({2'b00, pd_mode, din_c}) << PAD;
    dac_sclk_gen #(.DIV_HALF(DIV_HALF)) u_sclk (
        .clk       (clk),
        .rst       (rst),
        .en_i      (state_q == SHIFT),
        .sclk_o    (sclk),
        .rise_en_o (rise_en),
        .fall_en_o (fall_en)
    );
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        gap_d   = gap_q;
        sync_d  = sync_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (tx_start) begin
                state_d = SHIFT;
                shift_d = frame;
                bit_d   = '0;
                sync_d  = 1'b0;
            end
            SHIFT: if (rise_en) begin
                if (bit_q == 4'd15) begin
                    state_d = GAP;
                    shift_d = '0;
                    sync_d  = 1'b1;
                    gap_d   = '0;
                end else begin
                    shift_d = shift_q << 1;
                    bit_d   = bit_q + 1'b1;
                end
            end
            GAP: if (gap_q == GW'(GAP_CYC - 1)) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end else begin
                gap_d = gap_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            gap_q   <= '0;
            sync_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            gap_q   <= gap_d;
            sync_q  <= sync_d;
            done_q  <= done_d;
        end
    end
    // SCLK may only fall while a frame is being shifted
    assert property (@(posedge clk) disable iff (!rst) fall_en |-> state_q == SHIFT);
    assign sync_n       = sync_q;
    assign sdata        = shift_q[FRAME_W-1];
    assign tx_busy      = state_q != IDLE;
    assign tx_done_tick = done_q;
endmodule

// File: tb/tb_dac_tx_serial.sv
// tb_dac_tx_serial: scoreboard bench; stimulus pushes expected frames, a monitor decodes the serial line.
module tb_dac_tx_serial;
    import dac_tx_pkg::*;
    logic clk = 1'b0, rst = 1'b0, tx_start = 1'b0;
    logic [11:0] din = '0;
    logic [1:0] pd_mode = PD_NORMAL;
    logic sync_n, sclk, sdata, tx_busy, tx_done_tick;
    logic [15:0] exp_q[$];
    int checks = 0, errors = 0, done_cnt = 0, frames = 0;
    logic abort_exp = 1'b0;
    always #5 clk = ~clk;
    dac_tx_serial dut (
        .clk          (clk),
        .rst          (rst),
        .tx_start     (tx_start),
        .din          (din),
        .pd_mode      (pd_mode),
        .sync_n       (sync_n),
        .sclk         (sclk),
        .sdata        (sdata),
        .tx_busy      (tx_busy),
        .tx_done_tick (tx_done_tick)
    );
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask
    // Monitor: bits are captured on SCLK falling edges while SYNC is low
    initial begin
        logic prev_sclk = 1'b1, prev_sync = 1'b1, prev_done = 1'b0, prev_sdata = 1'b0;
        logic [15:0] sh = '0;
        int nb = 0;
        forever begin
            @(negedge clk);
            if (!sync_n && prev_sclk && !sclk) begin
                sh = {sh[14:0], sdata};
                nb++;
            end
            if (!sync_n && !prev_sync && sdata !== prev_sdata)
                chk("sdata_edge", 32'({prev_sclk, sclk}), 32'b01);
            if (sync_n && !prev_sync) begin
                if (nb == 16) begin
                    if (exp_q.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
                    else chk("frame", 32'(sh), 32'(exp_q.pop_front()));
                    frames++;
                end else chk("abort_partial", 32'(abort_exp), 32'd1);
                nb = 0;
            end
            if (tx_done_tick) begin
                chk("done_width", 32'(prev_done), 32'd0);
                done_cnt++;
            end
            prev_sclk  = sclk;
            prev_sync  = sync_n;
            prev_done  = tx_done_tick;
            prev_sdata = sdata;
        end
    end
    task automatic frame_timed(input logic [11:0] d, input logic [1:0] p, input logic [15:0] e);
        int low_cnt, done_at, busy_cnt;
        low_cnt = 0; done_at = 0; busy_cnt = 0;
        @(negedge clk);
        din = d; pd_mode = p; tx_start = 1'b1;
        exp_q.push_back(e);
        for (int c = 1; c <= 70; c++) begin
            @(negedge clk);
            tx_start = 1'b0;
            if (c == 1) begin
                chk("sync_latency", 32'(sync_n), 32'd0);
                din = ~d; pd_mode = ~p;
            end
            if (!sync_n) low_cnt++;
            if (tx_busy) busy_cnt++;
            if (tx_done_tick && done_at == 0) done_at = c;
        end
        chk("sync_low_len", 32'(low_cnt), 32'd64);
        chk("done_cycle", 32'(done_at), 32'd67);
        chk("busy_len", 32'(busy_cnt), 32'd66);
    endtask
    initial begin
        int d0, f0, second, hi;
        logic prev_s;
        repeat (3) @(negedge clk);
        chk("in_reset", 32'({sync_n, sclk, sdata, tx_busy, tx_done_tick}), 32'b11000);
        rst = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            chk("reset_idle", 32'({sync_n, sclk, sdata, tx_busy, tx_done_tick}), 32'b11000);
        end
        frame_timed(12'hA5C, PD_NORMAL, 16'h0A5C);
        // back-to-back with tx_start held high
        @(negedge clk);
        din = 12'hFFF; pd_mode = PD_NORMAL; tx_start = 1'b1;
        exp_q.push_back(16'h0FFF);
        exp_q.push_back(16'h0001);
        second = 0; hi = 0; prev_s = 1'b0;
        for (int c = 1; c <= 140; c++) begin
            @(negedge clk);
            if (c == 1) din = 12'h001;
            if (sync_n && second == 0) hi++;
            if (!sync_n && prev_s && second == 0) begin
                second = c;
                tx_start = 1'b0;
            end
            prev_s = sync_n;
        end
        chk("b2b_second_start", 32'(second), 32'd68);
        chk("b2b_sync_gap", 32'(hi), 32'd3);
        // start while busy is ignored
        d0 = done_cnt; f0 = frames;
        @(negedge clk);
        din = 12'h456; tx_start = 1'b1;
        exp_q.push_back(16'h0456);
        for (int c = 1; c <= 150; c++) begin
            @(negedge clk);
            tx_start = 1'b0;
            if (c == 20) begin
                tx_start = 1'b1;
                din = 12'h123;
            end
        end
        chk("ignore_done_cnt", 32'(done_cnt - d0), 32'd1);
        chk("ignore_frames", 32'(frames - f0), 32'd1);
        // abort mid-frame
        d0 = done_cnt;
        @(negedge clk);
        din = 12'h3C5; tx_start = 1'b1; abort_exp = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            tx_start = 1'b0;
            if (c == 30) rst = 1'b0;
        end
        @(negedge clk);
        chk("abort_outputs", 32'({sync_n, sclk, tx_busy, tx_done_tick}), 32'b1100);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
        abort_exp = 1'b0;
        frame_timed(12'hA5C, PD_1K, 16'h1A5C);
`ifdef DAC_TX_TWOS_COMP_EN
        frame_timed(12'h800, PD_HIZ, 16'h3000);
        frame_timed(12'h7FF, PD_HIZ, 16'h3FFF);
`else
        frame_timed(12'h800, PD_HIZ, 16'h3800);
        frame_timed(12'h7FF, PD_HIZ, 16'h37FF);
`endif
        repeat (5) @(negedge clk);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
